// File: rtl/packet_word_pkg.sv
// Shared constants, state encoding and header-field helpers for the packet_word_rx receive path.
// The header layout mirrors the TX_WORD encoder: all fields sit in the 64 MSBs of the packet.
package packet_word_pkg;

  localparam int unsigned HDR_W     = 64;

  localparam int unsigned TICK_LSB  = 0;
  localparam int unsigned TICK_W    = 16;
  localparam int unsigned FLAGS_LSB = 16;
  localparam int unsigned FLAGS_W   = 4;
  localparam int unsigned LAGC_LSB  = 20;
  localparam int unsigned LAGC_W    = 8;
  localparam int unsigned LAGA_LSB  = 28;
  localparam int unsigned LAGA_W    = 8;
  localparam int unsigned DELAY_LSB = 36;
  localparam int unsigned DELAY_W   = 12;
  localparam int unsigned NIN_LSB   = 48;
  localparam int unsigned NIN_W     = 8;
  localparam int unsigned RES_LSB   = 56;
  localparam int unsigned RES_W     = 8;

  localparam logic [7:0] CR = 8'h0d;
  localparam logic [7:0] LF = 8'h0a;

  localparam logic [HDR_W-1:0] CAPTURE_MARKER = 64'hffff_ffff_ffff_ffff;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_SYNC = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [RES_W-1:0]   resolution;
    logic [NIN_W-1:0]   num_inputs;
    logic [DELAY_W-1:0] delay_size;
    logic [LAGA_W-1:0]  lag_auto;
    logic [LAGC_W-1:0]  lag_cross;
    logic [FLAGS_W-1:0] flags;
    logic [TICK_W-1:0]  tick;
  } hdr_fields_t;

  function automatic hdr_fields_t header_decode(input logic [HDR_W-1:0] hdr);
    hdr_fields_t f;
    f.tick       = hdr[TICK_LSB  +: TICK_W];
    f.flags      = hdr[FLAGS_LSB +: FLAGS_W];
    f.lag_cross  = hdr[LAGC_LSB  +: LAGC_W];
    f.lag_auto   = hdr[LAGA_LSB  +: LAGA_W];
    f.delay_size = hdr[DELAY_LSB +: DELAY_W];
    f.num_inputs = hdr[NIN_LSB   +: NIN_W];
    f.resolution = hdr[RES_LSB   +: RES_W];
    return f;
  endfunction

endpackage

// File: rtl/packet_word_hex_nibble_decode.sv
// Combinational byte classifier: hex character -> nibble, CR/LF -> delimiter.
// In raw mode every byte is a nibble carried in its low four bits.
module hex_nibble_decode
  import packet_word_pkg::*;
#(
  parameter int unsigned BINARY = 0
) (
  input  logic [7:0] rx_byte,
  output logic       valid,
  output logic [3:0] nibble,
  output logic       is_delim
);

  always_comb begin
    valid    = 1'b0;
    nibble   = '0;
    is_delim = 1'b0;
    if (BINARY != 0) begin
      valid  = 1'b1;
      nibble = rx_byte[3:0];
    end else if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      valid  = 1'b1;
      nibble = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      valid  = 1'b1;
      nibble = rx_byte[3:0] + 4'd9;
    end else if (rx_byte == CR || rx_byte == LF) begin
      is_delim = 1'b1;
    end
  end

endmodule

// File: rtl/packet_word_rx.sv
// Receive-side decoder for the correlator packet stream: reassembles nibbles into a packet,
// commits it on the delimiter (or on the last nibble in raw mode) and decodes the header.
module packet_word_rx
  import packet_word_pkg::*;
#(
  parameter int unsigned PACKET_SIZE = 192,
  parameter int unsigned HEADER_SIZE = 64,
  parameter int unsigned FOOTER_SIZE = 64,
  parameter int unsigned BINARY      = 0
) (
  input  logic                   sysclk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [7:0]             RXREG,
  input  logic                   RXIF,
  output logic [PACKET_SIZE-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   capture_start,
  output logic [15:0]            tick,
  output logic [3:0]             flags,
  output logic [7:0]             lag_cross,
  output logic [7:0]             lag_auto,
  output logic [11:0]            delay_size,
  output logic [7:0]             num_inputs,
  output logic [7:0]             resolution,
  output logic [63:0]            timestamp,
  output logic                   frame_err
);

  localparam int unsigned TOTAL_NIBBLES = PACKET_SIZE / 4;
  localparam int unsigned CNT_W         = $clog2(TOTAL_NIBBLES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL_NIBBLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL_NIBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                   nib_valid;
  logic [3:0]             nib;
  logic                   nib_delim;

  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PACKET_SIZE-1:0] sr_q, sr_d;
  logic [PACKET_SIZE-1:0] rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   capture_q, capture_d;
  logic                   frame_err_q, frame_err_d;
  hdr_fields_t            hdr_q, hdr_d;
  logic [63:0]            timestamp_q, timestamp_d;

  logic [PACKET_SIZE-1:0] sr_shift;
  logic                   commit;
  logic [PACKET_SIZE-1:0] commit_pkt;
  logic [HEADER_SIZE-1:0] hdr_raw;

  hex_nibble_decode #(
    .BINARY (BINARY)
  ) u_decode (
    .rx_byte  (RXREG),
    .valid    (nib_valid),
    .nibble   (nib),
    .is_delim (nib_delim)
  );

  assign sr_shift = {sr_q[PACKET_SIZE-5:0], nib};
  assign hdr_raw  = commit_pkt[PACKET_SIZE-1 -: HEADER_SIZE];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    rx_data_d   = rx_data_q;
    hdr_d       = hdr_q;
    timestamp_d = timestamp_q;
    rx_valid_d  = 1'b0;
    capture_d   = 1'b0;
    frame_err_d = 1'b0;
    commit      = 1'b0;
    commit_pkt  = sr_q;

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (RXIF) begin
      unique case (state_q)
        ST_IDLE: begin
          if (nib_valid) begin
            sr_d    = sr_shift;
            cnt_d   = CNT_ONE;
            state_d = ST_RECV;
          end else if (!nib_delim) begin
            frame_err_d = 1'b1;
            state_d     = ST_SYNC;
          end
        end

        ST_RECV: begin
          if (BINARY != 0) begin
            // Raw mode has no delimiter: the last nibble itself commits the packet.
            sr_d = sr_shift;
            if (cnt_q == CNT_LAST) begin
              commit     = 1'b1;
              commit_pkt = sr_shift;
              cnt_d      = '0;
              state_d    = ST_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (nib_valid) begin
            if (cnt_q < CNT_FULL) begin
              sr_d  = sr_shift;
              cnt_d = cnt_q + CNT_ONE;
            end else begin
              frame_err_d = 1'b1;
              cnt_d       = '0;
              state_d     = ST_SYNC;
            end
          end else if (nib_delim) begin
            if (cnt_q == CNT_FULL) begin
              commit = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_SYNC;
          end
        end

        ST_SYNC: begin
          if (nib_delim) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (commit) begin
      rx_data_d   = commit_pkt;
      timestamp_d = 64'(commit_pkt[FOOTER_SIZE-1:0]);
      rx_valid_d  = 1'b1;
      // The capture marker is a control frame: it must not disturb the decoded descriptor.
      if (hdr_raw == CAPTURE_MARKER) begin
        capture_d = 1'b1;
      end else begin
        hdr_d = header_decode(hdr_raw);
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      capture_q   <= 1'b0;
      frame_err_q <= 1'b0;
      hdr_q       <= '0;
      timestamp_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      capture_q   <= capture_d;
      frame_err_q <= frame_err_d;
      hdr_q       <= hdr_d;
      timestamp_q <= timestamp_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign capture_start = capture_q;
  assign frame_err     = frame_err_q;
  assign tick          = hdr_q.tick;
  assign flags         = hdr_q.flags;
  assign lag_cross     = hdr_q.lag_cross;
  assign lag_auto      = hdr_q.lag_auto;
  assign delay_size    = hdr_q.delay_size;
  assign num_inputs    = hdr_q.num_inputs;
  assign resolution    = hdr_q.resolution;
  assign timestamp     = timestamp_q;

endmodule

// File: tb/tb_packet_word_rx.sv
// Scoreboard bench for packet_word_rx: an ASCII instance and a raw-nibble instance
// share one expectation queue drained by a negedge monitor.
module tb_packet_word_rx;

  logic        sysclk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  rxreg_a, rxreg_b;
  logic        rxif_a, rxif_b;

  logic [191:0] rx_data_a, rx_data_b;
  logic         rx_valid_a, rx_valid_b, cap_a, cap_b, ferr_a, ferr_b;
  logic [15:0]  tick_a, tick_b;
  logic [3:0]   flags_a, flags_b;
  logic [7:0]   lagc_a, lagc_b, laga_a, laga_b, nin_a, nin_b, res_a, res_b;
  logic [11:0]  delay_a, delay_b;
  logic [63:0]  ts_a, ts_b;

  always #5 sysclk = ~sysclk;

  packet_word_rx #(.PACKET_SIZE(192), .HEADER_SIZE(64), .FOOTER_SIZE(64), .BINARY(0)) dut_a (
    .sysclk(sysclk), .reset_n(reset_n), .enable(enable), .RXREG(rxreg_a), .RXIF(rxif_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .capture_start(cap_a), .tick(tick_a),
    .flags(flags_a), .lag_cross(lagc_a), .lag_auto(laga_a), .delay_size(delay_a),
    .num_inputs(nin_a), .resolution(res_a), .timestamp(ts_a), .frame_err(ferr_a)
  );

  packet_word_rx #(.PACKET_SIZE(192), .HEADER_SIZE(64), .FOOTER_SIZE(64), .BINARY(1)) dut_b (
    .sysclk(sysclk), .reset_n(reset_n), .enable(enable), .RXREG(rxreg_b), .RXIF(rxif_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .capture_start(cap_b), .tick(tick_b),
    .flags(flags_b), .lag_cross(lagc_b), .lag_auto(laga_b), .delay_size(delay_b),
    .num_inputs(nin_b), .resolution(res_b), .timestamp(ts_b), .frame_err(ferr_b)
  );

  typedef struct {
    logic [15:0] tick;
    logic [3:0]  flags;
    logic [7:0]  lagc;
    logic [7:0]  laga;
    logic [11:0] delay;
    logic [7:0]  nin;
    logic [7:0]  res;
  } fields_t;

  typedef struct {
    int unsigned  dut;
    bit           is_err;
    bit           cap;
    logic [191:0] data;
    fields_t      f;
    int unsigned  cyc;
  } exp_t;

  exp_t        q[$];
  fields_t     m_a, m_b;
  int unsigned cyc = 0;
  int          err_cnt = 0;
  int          chk_cnt = 0;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] expv);
    chk_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic fields_t zero_fields();
    fields_t f;
    f.tick = '0; f.flags = '0; f.lagc = '0; f.laga = '0; f.delay = '0; f.nin = '0; f.res = '0;
    return f;
  endfunction

  task automatic push_valid(input int unsigned which, input logic [191:0] pkt, input int unsigned c);
    exp_t        e;
    logic [63:0] h;
    fields_t     m;
    h = pkt[191:128];
    m = (which == 0) ? m_a : m_b;
    e.dut = which; e.is_err = 1'b0; e.data = pkt; e.cyc = c;
    e.cap = (h == 64'hffff_ffff_ffff_ffff);
    if (!e.cap) begin
      m.tick = h[15:0];   m.flags = h[19:16]; m.lagc = h[27:20]; m.laga = h[35:28];
      m.delay = h[47:36]; m.nin = h[55:48];   m.res = h[63:56];
    end
    e.f = m;
    if (which == 0) m_a = m; else m_b = m;
    q.push_back(e);
  endtask

  task automatic push_err(input int unsigned c);
    exp_t e;
    e.dut = 0; e.is_err = 1'b1; e.cap = 1'b0; e.data = '0; e.f = zero_fields(); e.cyc = c;
    q.push_back(e);
  endtask

  task automatic handle(input int unsigned which, input logic v, input logic fe, input logic cs,
                        input logic [191:0] d, input fields_t got, input logic [63:0] ts);
    exp_t  e;
    string p;
    p = $sformatf("dut%0d_", which);
    if (!(v || fe || cs)) return;
    if (q.size() == 0 || q[0].dut != which) begin
      chk({p, "unexpected_pulse"}, {v, fe, cs}, 0);
      return;
    end
    e = q.pop_front();
    chk({p, "cycle"}, cyc, e.cyc);
    chk({p, "frame_err"}, fe, e.is_err);
    chk({p, "rx_valid"}, v, !e.is_err);
    if (!e.is_err) begin
      chk({p, "capture_start"}, cs, e.cap);
      chk({p, "rx_data"}, d, e.data);
      chk({p, "timestamp"}, ts, e.data[63:0]);
      chk({p, "tick"}, got.tick, e.f.tick);
      chk({p, "flags"}, got.flags, e.f.flags);
      chk({p, "lag_cross"}, got.lagc, e.f.lagc);
      chk({p, "lag_auto"}, got.laga, e.f.laga);
      chk({p, "delay_size"}, got.delay, e.f.delay);
      chk({p, "num_inputs"}, got.nin, e.f.nin);
      chk({p, "resolution"}, got.res, e.f.res);
    end
  endtask

  initial begin
    fields_t ga, gb;
    forever begin
      @(negedge sysclk);
      ga.tick = tick_a; ga.flags = flags_a; ga.lagc = lagc_a; ga.laga = laga_a;
      ga.delay = delay_a; ga.nin = nin_a; ga.res = res_a;
      gb.tick = tick_b; gb.flags = flags_b; gb.lagc = lagc_b; gb.laga = laga_b;
      gb.delay = delay_b; gb.nin = nin_b; gb.res = res_b;
      handle(0, rx_valid_a, ferr_a, cap_a, rx_data_a, ga, ts_a);
      handle(1, rx_valid_b, ferr_b, cap_b, rx_data_b, gb, ts_b);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [7:0] hexc(input logic [3:0] n, input bit lower);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (lower ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
  endfunction

  task automatic send_a(input logic [7:0] b);
    rxreg_a = b; rxif_a = 1'b1;
    @(posedge sysclk); #1;
    rxif_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    rxreg_b = b; rxif_b = 1'b1;
    @(posedge sysclk); #1;
    rxif_b = 1'b0;
  endtask

  task automatic send_chars(input logic [191:0] pkt, input int nchars, input bit lower);
    logic [3:0] n;
    for (int i = 0; i < nchars; i++) begin
      n = (i < 48) ? pkt[191 - 4*i -: 4] : 4'h0;
      send_a(hexc(n, lower && (i % 2 == 1)));
    end
  endtask

  task automatic good_frame(input logic [191:0] pkt, input logic [7:0] delim, input bit lower);
    send_chars(pkt, 48, lower);
    push_valid(0, pkt, cyc + 1);
    send_a(delim);
  endtask

  localparam logic [191:0] PKT1 = {64'h0807_0040_3031_09C4, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_0000_1234};
  localparam logic [191:0] PKT2 = {64'hFFFF_FFFF_FFFF_FFFF, 64'hA5A5_A5A5_5A5A_5A5A, 64'h0000_0000_CAFE_0002};
  localparam logic [191:0] PKT3 = {64'h100F_1230_7052_BEEF, 64'h0F1E_2D3C_4B5A_6978, 64'h1122_3344_5566_7788};
  localparam logic [191:0] PKT4 = {64'h203F_0FF1_F0F8_0001, 64'hDEAD_BEEF_00C0_FFEE, 64'h0000_0000_0000_0001};

  initial begin
    logic [191:0] pb;
    logic [3:0]   nv [3];
    m_a = zero_fields(); m_b = zero_fields();
    reset_n = 1'b0; enable = 1'b1;
    rxreg_a = '0; rxif_a = 1'b0; rxreg_b = '0; rxif_b = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    chk("reset_rx_data", rx_data_a, 0);
    chk("reset_tick", tick_a, 0);
    chk("reset_timestamp", ts_a, 0);
    chk("reset_pulses", {rx_valid_a, cap_a, ferr_a, rx_valid_b}, 0);
    chk("reset_rx_data_bin", rx_data_b, 0);
    reset_n = 1'b1;
    @(posedge sysclk); #1;

    // Stray delimiters in IDLE are ignored, then a full frame with CR.
    send_a(8'h0a); send_a(8'h0d);
    good_frame(PKT1, 8'h0d, 1'b0);
    chk("t1_tick", tick_a, 16'h09C4);
    chk("t1_flags", flags_a, 4'h1);
    chk("t1_lag_cross", lagc_a, 8'h03);
    chk("t1_lag_auto", laga_a, 8'h03);
    chk("t1_delay_size", delay_a, 12'h004);
    chk("t1_num_inputs", nin_a, 8'h07);
    chk("t1_resolution", res_a, 8'h08);
    chk("t1_timestamp_lo", ts_a[15:0], 16'h1234);

    // Capture marker with LF and mixed-case hex.
    good_frame(PKT2, 8'h0a, 1'b1);
    chk("t2_tick_held", tick_a, 16'h09C4);
    chk("t2_resolution_held", res_a, 8'h08);
    chk("t2_timestamp", ts_a, 64'h0000_0000_CAFE_0002);

    // Short frame.
    send_chars(PKT3, 47, 1'b0);
    push_err(cyc + 1);
    send_a(8'h0d);
    good_frame(PKT3, 8'h0d, 1'b1);

    // Long frame, then garbage while resynchronising.
    send_chars(PKT4, 48, 1'b0);
    push_err(cyc + 1);
    send_a(8'h30);
    send_a(8'h47);
    send_chars(PKT1, 5, 1'b0);
    send_a(8'h0d);
    good_frame(PKT4, 8'h0d, 1'b0);
    chk("t4_delay_size", delay_a, 12'h0FF);

    // Raw-nibble instance: three frames strobed back-to-back, the last is a capture marker.
    nv[0] = 4'h5; nv[1] = 4'hC; nv[2] = 4'hF;
    for (int f = 0; f < 3; f++) begin
      pb = {48{nv[f]}};
      for (int i = 0; i < 48; i++) begin
        if (i == 47) push_valid(1, pb, cyc + 1);
        send_b({4'hA, nv[f]});
      end
    end
    @(posedge sysclk); #1;
    chk("t5_bin_tick", tick_b, 16'hCCCC);
    chk("t5_bin_rx_data", rx_data_b, {48{4'hF}});

    // Asynchronous reset mid-frame.
    send_chars(PKT1, 20, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_rx_data", rx_data_a, 0);
    chk("t6_rst_fields", {tick_a, flags_a, lagc_a, laga_a, delay_a, nin_a, res_a}, 0);
    chk("t6_rst_timestamp", ts_a, 0);
    chk("t6_rst_bin_tick", tick_b, 0);
    m_a = zero_fields(); m_b = zero_fields();
    @(posedge sysclk); #1;
    reset_n = 1'b1;
    @(posedge sysclk); #1;
    good_frame(PKT3, 8'h0d, 1'b0);

    // Enable dropped mid-frame: partial discarded, outputs held, strobes ignored.
    send_chars(PKT1, 20, 1'b0);
    enable = 1'b0;
    send_chars(PKT2, 3, 1'b0);
    send_a(8'h0d);
    chk("t6_en_tick_held", tick_a, 16'hBEEF);
    chk("t6_en_timestamp_held", ts_a, 64'h1122_3344_5566_7788);
    chk("t6_en_rx_data_held", rx_data_a, PKT3);
    enable = 1'b1;
    @(posedge sysclk); #1;
    good_frame(PKT4, 8'h0d, 1'b1);

    repeat (5) @(posedge sysclk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
